// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external SRAM/bus slave between instruction fetch (IF) and
//   the load/store path (MEM). MEM has fixed priority over IF. Each side
//   gets a one-cycle ack pulse with its read data. Combinational stall
//   requests let the pipeline freeze the stages that are waiting.
//
//   Optional feature: define MEM_ARB_TIMEOUT_EN to abort a bus cycle that
//   has waited TIMEOUT cycles without bus_ack. The requester then gets an
//   ack with zero data, and bus_err pulses for one cycle. Without the macro
//   the arbiter waits for bus_ack indefinitely, and bus_err stays 0.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   if_*              fetch requester: req/addr in, ack/rdata out
//   mem_*             data requester: req/we/sel/addr/wdata in, ack/rdata out
//   bus_*             slave side: req/we/sel/addr/wdata out, ack/rdata in,
//                     plus the bus_err timeout pulse
//   stallreq_if/mem   request pending and not completing this cycle
//
// States
//   IDLE    | no bus cycle in flight, arbitrate the pending requests
//   BUS_MEM | bus cycle on behalf of MEM, waiting for bus_ack
//   BUS_IF  | bus cycle on behalf of IF, waiting for bus_ack

module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUS_MEM = 2'd1;
  localparam logic [1:0] BUS_IF  = 2'd2;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be at least 2");
  end

  logic [1:0] state;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`endif

  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = mem_req & ~mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'h0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          // A request whose ack is high right now has just been served and
          // is still held by the requester, so it must not be granted again.
          if (mem_req && !mem_ack) begin
            state     <= BUS_MEM;
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (if_req && !if_ack) begin
            state     <= BUS_IF;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'hF;
            bus_addr  <= if_addr;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        BUS_MEM, BUS_IF: begin
          // bus_ack wins over a timeout that lands in the same cycle.
          if (bus_ack) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            if (state == BUS_MEM) begin
              mem_ack   <= 1'b1;
              mem_rdata <= bus_rdata;
            end else begin
              if_ack    <= 1'b1;
              if_rdata  <= bus_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            if (state == BUS_MEM) begin
              mem_ack   <= 1'b1;
              mem_rdata <= '0;
            end else begin
              if_ack    <= 1'b1;
              if_rdata  <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_sel;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          bus_err;
  logic          stallreq_if;
  logic          stallreq_mem;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One scenario starting from an idle arbiter. Requests rise in cycle 0.
  // The first owner (MEM if present) sees bus_req in cycles 1..lat_a and
  // bus_ack in cycle lat_a, so its ack lands in cycle lat_a+1. A second
  // requester is granted in that ack cycle, so its bus_req spans
  // lat_a+2..lat_a+1+lat_b and its ack lands in cycle lat_a+2+lat_b.
  task automatic run_txn(input bit has_m, input bit has_i, input bit m_we,
                         input logic [3:0] m_sel, input logic [31:0] m_addr,
                         input logic [31:0] m_wdata, input logic [31:0] i_addr,
                         input int lat_a, input int lat_b,
                         input logic [31:0] rd_a, input logic [31:0] rd_b,
                         input bit scramble, input bit stray);
    bit two;
    int a_done, b_start, b_ack, b_done, m_done, i_done, last;
    logic [31:0] m_rd, i_rd;
    bit win_a, win_b, ebus, e_mack, e_iack, mem_is_owner;
    two     = has_m && has_i;
    a_done  = lat_a + 1;
    b_start = lat_a + 2;
    b_ack   = lat_a + 1 + lat_b;
    b_done  = lat_a + 2 + lat_b;
    m_done  = has_m ? a_done : -1;
    i_done  = has_m ? (has_i ? b_done : -1) : a_done;
    m_rd    = rd_a;
    i_rd    = has_m ? rd_b : rd_a;
    last    = (two ? b_done : a_done) + 1;
    for (int k = 0; k <= last; k++) begin
      win_a = (k >= 1) && (k <= lat_a);
      win_b = two && (k >= b_start) && (k <= b_ack);
      mem_req = has_m && (k <= m_done);
      if_req  = has_i && (k <= i_done);
      if (scramble && has_m && win_a) begin
        mem_we = $urandom_range(0, 1); mem_sel = 4'($urandom);
        mem_addr = $urandom; mem_wdata = $urandom;
      end else begin
        mem_we = m_we; mem_sel = m_sel; mem_addr = m_addr; mem_wdata = m_wdata;
      end
      if (scramble && ((!has_m && win_a) || win_b)) if_addr = $urandom;
      else if_addr = i_addr;
      bus_ack = (k == lat_a) || (two && k == b_ack) ||
                (stray && (k == 0 || k == last));
      if (k == lat_a) bus_rdata = rd_a;
      else if (two && k == b_ack) bus_rdata = rd_b;
      else bus_rdata = $urandom;
      #1;
      ebus   = win_a || win_b;
      e_mack = (k == m_done);
      e_iack = (k == i_done);
      chk("bus_req", bus_req, ebus);
      chk("mem_ack", mem_ack, e_mack);
      chk("if_ack", if_ack, e_iack);
      chk("bus_err", bus_err, 1'b0);
      chk("ack_overlap", if_ack & mem_ack, 1'b0);
      chk("stallreq_mem", stallreq_mem, mem_req & ~e_mack);
      chk("stallreq_if", stallreq_if, if_req & ~e_iack);
      if (ebus) begin
        mem_is_owner = win_a && has_m;
        if (mem_is_owner) begin
          chk("bus_addr_m", bus_addr, m_addr);
          chk("bus_we_m", bus_we, m_we);
          chk("bus_sel_m", bus_sel, m_sel);
          chk("bus_wdata_m", bus_wdata, m_wdata);
        end else begin
          chk("bus_addr_i", bus_addr, i_addr);
          chk("bus_we_i", bus_we, 1'b0);
          chk("bus_sel_i", bus_sel, 4'hF);
        end
      end
      if (e_mack) chk("mem_rdata", mem_rdata, m_rd);
      if (e_iack) chk("if_rdata", if_rdata, i_rd);
      next_cycle();
    end
    mem_req = 1'b0; if_req = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    // reset held with a pending fetch
    repeat (3) begin
      next_cycle();
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_if_ack", if_ack, 1'b0);
      chk("rst_mem_ack", mem_ack, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
    end
    rst = 1'b0;
    next_cycle();
    chk("rel_bus_req", bus_req, 1'b1);
    chk("rel_bus_addr", bus_addr, 32'h100);
    chk("rel_bus_sel", bus_sel, 4'hF);

    // reset in the middle of the fetch, then a stray late ack
    rst = 1'b1;
    next_cycle();
    chk("midrst_bus_req", bus_req, 1'b0);
    rst = 1'b0; if_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    repeat (3) begin
      next_cycle();
      chk("stray_bus_req", bus_req, 1'b0);
      chk("stray_if_ack", if_ack, 1'b0);
      chk("stray_mem_ack", mem_ack, 1'b0);
    end
    bus_ack = 1'b0;
    next_cycle();

    // directed scenarios
    run_txn(0, 1, 0, 4'h0, 32'h0, 32'h0, 32'h100, 2, 0, 32'h34011100, 32'h0, 0, 0);
    run_txn(1, 1, 0, 4'hF, 32'h2000, 32'h0, 32'h104, 1, 1, 32'h11223344, 32'h55667788, 0, 0);
    run_txn(1, 0, 1, 4'b0011, 32'h2004, 32'hDEADBEEF, 32'h0, 3, 0, 32'hA5A5A5A5, 32'h0, 1, 0);
    run_txn(1, 1, 1, 4'b0011, 32'h2004, 32'hDEADBEEF, 32'h108, 3, 2, 32'h01010101, 32'h02020202, 1, 1);

    // randomized scenarios
    for (int it = 0; it < 40; it++) begin
      int sel_kind;
      sel_kind = $urandom_range(0, 2);
      run_txn(sel_kind != 1, sel_kind != 0, 1'($urandom_range(0, 1)), 4'($urandom),
              $urandom, $urandom, $urandom,
              $urandom_range(1, 4), $urandom_range(1, 4),
              $urandom | 32'h1, $urandom | 32'h1,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // slave never answers: abort after TMO bus cycles
    mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h3000; bus_ack = 1'b0;
    for (int k = 0; k <= TMO + 2; k++) begin
      mem_req = (k <= TMO + 1);
      bus_rdata = $urandom;
      #1;
      chk("tmo_bus_req", bus_req, (k >= 1) && (k <= TMO));
      chk("tmo_mem_ack", mem_ack, k == TMO + 1);
      chk("tmo_bus_err", bus_err, k == TMO + 1);
      if (k == TMO + 1) chk("tmo_mem_rdata", mem_rdata, 32'h0);
      next_cycle();
    end
    mem_req = 1'b0;
    // ack on the limit cycle completes normally
    run_txn(1, 0, 0, 4'hF, 32'h3004, 32'h0, 32'h0, TMO, 0, 32'h77777777, 32'h0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Single-port memory bus arbiter for the five-stage core. It shares one external SRAM/bus slave between two requesters: instruction fetch (IF) and the load/store path (MEM stage).
- Each requester uses a req/ack handshake; the bus side uses req/ack with variable slave latency.
- Emits per-requester stall requests so the pipeline controller can freeze the affected stages while an access is outstanding.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT, 255, max cycles spent waiting for bus_ack (used only with MEM_ARB_TIMEOUT_EN); must be ≥2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse to IF.
- mem_req  in  1  data request; held until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_sel  in  4  byte-lane enables.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid while mem_ack=1.
- mem_ack  out  1  one-cycle completion pulse to MEM.
- bus_req  out  1  bus cycle active.
- bus_we  out  1  bus write enable.
- bus_sel  out  4  bus byte lanes.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  slave read data; sampled when bus_ack=1.
- bus_ack  in  1  slave completion.
- bus_err  out  1  timeout error pulse; constant 0 without the macro.
- stallreq_if  out  1  = if_req & ~if_ack (combinational).
- stallreq_mem  out  1  = mem_req & ~mem_ack (combinational).

Behaviour:
- Reset: on a clk edge with rst=1, state <= IDLE and all registered outputs <= 0: bus_req, bus_we, bus_sel, bus_addr, bus_wdata, if_ack, mem_ack, if_rdata, mem_rdata, bus_err. Timeout counter <= 0. An in-flight bus cycle is abandoned and any late bus_ack is ignored.
- States: IDLE, BUS_MEM, BUS_IF.
- IDLE:
  - Eligible requests: mem_req & ~mem_ack, and if_req & ~if_ack. A request whose ack is high this cycle is never re-granted.
  - Fixed priority: MEM over IF. MEM holds the older instruction; the pipeline freeze prevents starvation.
  - On grant, latch addr/we/sel/wdata into the bus_* registers, set bus_req=1, and go to BUS_MEM or BUS_IF.
  - IF grants drive bus_we=0 and bus_sel=4'b1111.
- BUS_x:
  - bus_* outputs are held stable.
  - Requester inputs are not re-sampled, so changes to them mid-cycle are ignored.
  - On bus_ack=1: capture bus_rdata into x_rdata, x_ack <= 1 for exactly one cycle, bus_req <= 0, state <= IDLE.
  - Stores return x_rdata = bus_rdata unmodified; the requester ignores it.
- Latency:
  - Request at cycle N (in IDLE) → bus_req at N+1.
  - Slave ack at cycle M ≥ N+1 → x_ack at M+1.
  - Minimum round trip is 2 cycles.
- Back-to-back: in the cycle x_ack=1 the FSM is already in IDLE and may grant the other requester. The next bus_req rises the following cycle, leaving one bus-idle cycle between transactions.
- bus_ack while in IDLE is ignored.
- x_ack never asserts without a prior grant. if_ack and mem_ack are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter clears on entering BUS_x and increments each cycle without bus_ack.
  - When it reaches TIMEOUT-1 with no ack: bus_req <= 0, state <= IDLE, x_ack <= 1 with x_rdata <= 0, and bus_err <= 1, both for one cycle.
  - bus_ack in the same cycle as the limit takes priority: normal completion, no error.
- Disabled: no counter; BUS_x waits indefinitely; bus_err tied 0.

Test Plan:
- Reset: hold rst=1 for 3 cycles while driving if_req=1 → all outputs 0 and bus_req stays 0. Release rst → bus_req=1 one cycle later.
- IF read: if_req=1, if_addr=0x00000100; slave acks 1 cycle after bus_req with 0x34011100 → bus_addr=0x100 and bus_sel=4'hF at N+1; if_ack=1 with if_rdata=0x34011100 at N+3 (ack at N+2, with slave ack 1 cycle after bus_req); stallreq_if=1 for cycles N..N+2.
- Simultaneous requests: if_req and mem_req (load 0x2000) rise together → MEM is granted first. After the mem_ack cycle, bus_req for IF addr rises exactly 1 cycle later. if_ack and mem_ack never overlap.
- Store: mem_we=1, mem_sel=4'b0011, mem_addr=0x2004, mem_wdata=0xDEADBEEF; slave latency 3 → bus_* stable for all 3 cycles; mem_ack pulses once; no IF grant while BUS_MEM.
- Reset mid-transaction: assert rst during BUS_IF before bus_ack → bus_req=0 next cycle, if_ack never pulses, and a later stray bus_ack is ignored.
- Timeout (macro on, TIMEOUT=4): slave never acks → mem_ack=1, mem_rdata=0, bus_err=1 in the same single cycle, bus_req dropped. Repeat with ack on the limit cycle → normal completion, bus_err=0.
